// File: rtl/display_timing_gen.sv
// Raster timing generator: Clk divider, pixel/line counters, registered sync/blank/strobes.
// Define DISPLAY_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module display_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 12
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          en,
    output logic          pix_ce,
    output logic          pixel_clk,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt,
    output logic          running
);
    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] STOPPING = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic          hc_wrap, vc_wrap;
    logic          active_d, blank_d, hs_on_d, vs_on_d;
    logic          pixel_clk_q, hs_q, vs_q, blank_q, line_start_q, frame_start_q;

    assign pix_ce  = (dcnt_q == DW'(CLK_DIV - 1));
    assign hc_wrap = (hc_q == CW'(HT - 1));
    assign vc_wrap = (vc_q == CW'(VT - 1));

    always_comb begin
        dcnt_d  = pix_ce ? '0 : dcnt_q + 1'b1;
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        case (state_q)
            IDLE:     if (pix_ce && en) state_d = RUN;
            RUN:      if (!en) state_d = STOPPING;
            STOPPING: begin
                if (en) state_d = RUN;
                else if (pix_ce && hc_wrap && vc_wrap) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        // Counters only move while a frame is in flight; IDLE parks them at 0,0.
        if (state_q != IDLE && pix_ce) begin
            hc_d = hc_wrap ? '0 : hc_q + 1'b1;
            if (hc_wrap) vc_d = vc_wrap ? '0 : vc_q + 1'b1;
        end
    end

    // Decoding the next counts lets the registered flags line up with DrawX/DrawY.
    always_comb begin
        active_d = (state_d != IDLE);
        blank_d  = active_d && (32'(hc_d) < H_ACTIVE) && (32'(vc_d) < V_ACTIVE);
        hs_on_d  = active_d && (32'(hc_d) >= H_ACTIVE + H_FP)
                            && (32'(hc_d) <  H_ACTIVE + H_FP + H_SYNC);
        vs_on_d  = active_d && (32'(vc_d) >= V_ACTIVE + V_FP)
                            && (32'(vc_d) <  V_ACTIVE + V_FP + V_SYNC);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            dcnt_q        <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            pixel_clk_q   <= 1'b1;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            pixel_clk_q   <= (dcnt_d < DW'(CLK_DIV / 2));
            hs_q          <= hs_on_d ? HS_POL : ~HS_POL;
            vs_q          <= vs_on_d ? VS_POL : ~VS_POL;
            blank_q       <= blank_d;
            line_start_q  <= active_d && (hc_d == '0);
            frame_start_q <= active_d && (hc_d == '0) && (vc_d == '0);
        end
    end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt_q <= '0;
        end else if (state_q != IDLE && pix_ce && hc_wrap && vc_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign pixel_clk   = pixel_clk_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = (state_q != IDLE);

    param_check: assert property (@(posedge Clk)
        (64'(HT) <= (64'd1 << CW)) && (64'(VT) <= (64'd1 << CW))
        && (CLK_DIV >= 2) && (CLK_DIV <= 16));

endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_DIV, 2: Clk cycles per pixel; legal range 2..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: hs active level.
- VS_POL, 0: vs active level.
- CW, 12: coordinate and counter width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- Clk, in, 1: single system clock.
- Reset, in, 1: asynchronous, active-high reset.
- en, in, 1: run request.
- pix_ce, out, 1: one-Clk-cycle pixel-advance strobe.
- pixel_clk, out, 1: divided pixel clock for the DAC.
- hs, out, 1: horizontal sync.
- vs, out, 1: vertical sync.
- blank, out, 1: active-low blanking, 1 inside the visible area.
- sync, out, 1: composite sync, tied to 0.
- DrawX, out, CW: horizontal coordinate.
- DrawY, out, CW: vertical coordinate.
- line_start, out, 1: one-pixel pulse at hc==0.
- frame_start, out, 1: one-pixel pulse at hc==0 and vc==0.
- frame_cnt, out, 16: completed-frame count.
- running, out, 1: the generator is in RUN or STOPPING.

REQ-003 Clk SHALL be the only clock; every flop SHALL be clocked on posedge Clk and reset by Reset asynchronously; there SHALL be no derived-clock flops.

Function
REQ-004 The divider dcnt SHALL count 0..CLK_DIV-1 and wrap; pix_ce=1 exactly when dcnt==CLK_DIV-1.
REQ-005 pixel_clk SHALL be 1 while dcnt < CLK_DIV/2 (floor), otherwise 0; it SHALL be registered and glitch-free.
REQ-006 HT = H_ACTIVE+H_FP+H_SYNC+H_BP and VT = V_ACTIVE+V_FP+V_SYNC+V_BP; hc and vc advance only on pix_ce.
REQ-007 hc SHALL count 0..HT-1; when hc reaches HT-1 it returns to 0 and vc increments; vc wraps from VT-1 to 0.
REQ-008 The hs active region SHALL be H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; vs active region SHALL be V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
REQ-009 hs and vs SHALL drive HS_POL/VS_POL when inside their active region, otherwise the inverse level.
REQ-010 blank=1 iff hc<H_ACTIVE and vc<V_ACTIVE; DrawX=hc and DrawY=vc.
REQ-011 hs, vs, blank, line_start and frame_start SHALL be registered, decoded from next-count values, so they align with DrawX/DrawY with zero cycles of skew.
REQ-012 The FSM SHALL have states IDLE, RUN and STOPPING.
- IDLE->RUN: on the first pix_ce with en=1.
- RUN->STOPPING: when en=0.
- STOPPING->RUN: when en=1 again, with no disturbance to the counters.
- STOPPING->IDLE: on the pix_ce that wraps hc=HT-1 and vc=VT-1 to 0,0.
REQ-013 In IDLE, hc=vc=0, blank=0, hs/vs are inactive, strobes are 0 and running=0; the divider keeps running.
REQ-014 The first pixel after IDLE->RUN SHALL be hc=0, vc=0 with frame_start=1.
REQ-015 The widths of hc and vc SHALL be CW; the parameters SHALL satisfy HT <= 2^CW and VT <= 2^CW (simulation assertion).

Reset
REQ-016 Reset SHALL force the following, including mid-frame, effective immediately:
- state=IDLE, dcnt=0, hc=vc=0;
- pixel_clk=1, pix_ce=0, blank=0;
- hs=~HS_POL, vs=~VS_POL;
- line_start=frame_start=0, frame_cnt=0, running=0.
REQ-017 After Reset deasserts, the first pix_ce SHALL occur CLK_DIV Clk cycles later.

Configuration
REQ-018 Macro DISPLAY_TIMING_FRAME_CNT_EN.
- Defined: frame_cnt SHALL increment, wrapping at 16 bits, on each pix_ce that wraps vc from VT-1 to 0.
- Undefined: frame_cnt SHALL be constant 0, with no counter logic.

Verification
REQ-019 Directed bench uses CLK_DIV=3 and H 4/1/2/1 (HT=8), V 3/1/1/1 (VT=6), HS_POL=VS_POL=0. It SHALL cover:
- Reset released with en=1: pix_ce every 3rd Clk, pixel_clk pattern 1,0,0; frame_start at hc=0,vc=0 on the first pix_ce.
- One line: blank=1 for hc 0..3; hs=0 for hc 5..6 only; line_start once per 8 pixels.
- One frame: vs=0 only for vc=4; 48 pixels per frame; with the macro defined, frame_cnt=1 after the first wrap.
- en dropped at vc=2, hc=3: the frame completes to hc=7,vc=5, then IDLE with running=0 and blank=0; en=1 restarts at 0,0 with frame_start.
- Reset asserted at hc=5, vc=3: all outputs are at reset values in the same cycle; without the macro, frame_cnt stays 0 throughout.
